accum_dump: RTL
===============

ACCUM_DUMP -- requirements
Module: accum_dump

Interface
REQ-001 SHALL have parameter DEPTH, default 256, number of accumulator entries (power of two); ADDR_W = log2(DEPTH).
REQ-002 SHALL have parameter DATA_W, default 160, entry width (128-bit key plus 32-bit count).
REQ-003 clk  in  1  single clock; all logic on posedge clk.
REQ-004 reset  in  1  synchronous, active-low reset (asserted when 0).
REQ-005 ready  out  1  high when reset is complete and the block accepts accum writes.
REQ-006 accum_addr  in  32  entry address from the search/accumulate stage.
REQ-007 accum_din  in  DATA_W  entry contents {key[159:32], count[31:0]}.
REQ-008 accum_we  in  1  write strobe, one entry per cycle, no backpressure.
REQ-009 kick  in  1  single-cycle pulse starting a drain.
REQ-010 busy  out  1  high from the cycle after an accepted kick until the drain completes.
REQ-011 dout  out  DATA_W  drained entry.
REQ-012 dout_valid  out  1  dout is valid; held with dout stable until dout_ready.
REQ-013 dout_ready  in  1  consumer accepts dout when dout_valid and dout_ready are both high.
REQ-014 addr_err  out  1  sticky; set when accum_we has accum_addr[31:ADDR_W] nonzero.

Function
REQ-015 SHALL store accum_din at entry accum_addr[ADDR_W-1:0] and set that entry's valid bit on accum_we when accum_addr[31:ADDR_W]==0; later writes overwrite.
REQ-016 SHALL drop writes with out-of-range address (no table change) and set addr_err.
REQ-017 SHALL accept kick only in IDLE with ready high; kick while busy or before ready is ignored.
REQ-018 States: IDLE, SCAN, READ, OUT, DONE; IDLE->SCAN on accepted kick, scan pointer = 0.
REQ-019 SCAN SHALL advance the pointer one entry per cycle past invalid entries; on a valid entry -> READ (one-cycle RAM read); READ -> OUT with dout loaded and dout_valid high.
REQ-020 OUT SHALL hold dout/dout_valid until handshake; on handshake clear the entry's valid bit, increment pointer, -> SCAN, or -> DONE if pointer was DEPTH-1.
REQ-021 SCAN at pointer DEPTH-1 with entry invalid -> DONE; DONE -> IDLE next cycle, busy low in IDLE.
REQ-022 Entries SHALL drain in ascending address order; empty table drain SHALL finish in DEPTH+1 cycles with no dout_valid.
REQ-023 accum_we during a drain SHALL be accepted; writes to addresses above the pointer are drained in this pass, at or below it remain for the next drain.
REQ-024 accum_we to the entry held in OUT SHALL update the table, leave dout unchanged, and leave the valid bit set after the handshake.
REQ-025 dout_valid SHALL never assert outside OUT; dout_ready outside OUT is ignored.

Reset
REQ-026 While reset is 0: state IDLE, all valid bits cleared, busy 0, dout_valid 0, dout 0, addr_err 0, ready 0.
REQ-027 ready SHALL rise one cycle after reset returns to 1; reset mid-drain aborts it and discards all entries.

Configuration
REQ-028 With ACCUM_DUMP_COUNT_EN defined: extra output drained_cnt [ADDR_W:0], cleared on accepted kick, incremented per handshake, held after DONE.
REQ-029 Without ACCUM_DUMP_COUNT_EN: no drained_cnt port or logic; all other behaviour identical.

Structure
REQ-030 KEY_W=128, CNT_W=32, DATA_W and the state enum SHALL live in the shared wordcount package.
REQ-031 Entry storage SHALL be a sub-module accum_dump_ram (simple dual-port, 1-cycle read latency); valid bits are flops in accum_dump.

Verification
REQ-032 Reset 10 cycles -> ready 0 during reset, 1 one cycle after; busy/dout_valid 0.
REQ-033 Write addr 3 {DEADBEEF_ABADCAFE_FEFEFEFE_34343434, 5a5a5a5a}, addr 7 {...,00000001}, kick, dout_ready=1 -> two beats, addr 3 then 7, busy falls; second kick drains nothing.
REQ-034 Same stimulus, dout_ready low 5 cycles per beat -> dout stable while held, no beat lost or duplicated.
REQ-035 During drain, write addr 200 while pointer<200 and addr 1 after it passed -> 200 emitted this pass, 1 on next kick.
REQ-036 accum_we addr 32'h0000_0100 (DEPTH 256) -> addr_err 1, table unchanged; reset mid-drain -> dout_valid 0, next drain empty.
REQ-037 With ACCUM_DUMP_COUNT_EN, drain of 2 entries -> drained_cnt 2; empty drain completes in 257 cycles with drained_cnt 0.

Source files
------------

// File: rtl/accum_dump_pkg.sv
// Shared wordcount package: entry geometry and the drain FSM state encoding
// used by accum_dump and its entry RAM.
package accum_dump_pkg;

  localparam int KEY_W  = 128;
  localparam int CNT_W  = 32;
  localparam int DATA_W = KEY_W + CNT_W;

  typedef enum logic [2:0] {
    S_IDLE,
    S_SCAN,
    S_READ,
    S_OUT,
    S_DONE
  } state_t;

endpackage

// File: rtl/accum_dump_ram.sv
// Entry storage for accum_dump: simple dual-port RAM, one write port and one
// read port with a registered, enable-gated read (1-cycle latency).
module accum_dump_ram #(
  parameter int DEPTH  = 256,
  parameter int DATA_W = 160,
  parameter int ADDR_W = $clog2(DEPTH)
) (
  input  logic              clk,
  input  logic              we,
  input  logic [ADDR_W-1:0] waddr,
  input  logic [DATA_W-1:0] wdata,
  input  logic              re,
  input  logic [ADDR_W-1:0] raddr,
  output logic [DATA_W-1:0] rdata
);

  logic [DATA_W-1:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    if (we) begin
      mem[waddr] <= wdata;
    end
  end

  // rdata only moves when re is pulsed, so it can be captured at leisure.
  always_ff @(posedge clk) begin
    if (re) begin
      rdata <= mem[raddr];
    end
  end

endmodule

// File: rtl/accum_dump.sv
// Accumulator table with ascending-order drain over a valid/ready stream.
// Optional feature: define ACCUM_DUMP_COUNT_EN to add the drained_cnt output.
module accum_dump #(
  parameter int DEPTH  = 256,
  parameter int DATA_W = accum_dump_pkg::DATA_W
) (
  input  logic                     clk,
  input  logic                     reset,
  output logic                     ready,
  input  logic [31:0]              accum_addr,
  input  logic [DATA_W-1:0]        accum_din,
  input  logic                     accum_we,
  input  logic                     kick,
  output logic                     busy,
  output logic [DATA_W-1:0]        dout,
  output logic                     dout_valid,
  input  logic                     dout_ready,
  output logic                     addr_err
`ifdef ACCUM_DUMP_COUNT_EN
  ,
  output logic [$clog2(DEPTH):0]   drained_cnt
`endif
);

  import accum_dump_pkg::*;

  localparam int ADDR_W = $clog2(DEPTH);

  state_t              state, state_nx;
  logic [DEPTH-1:0]    vld;
  logic [ADDR_W-1:0]   ptr;
  logic                dirty;
  logic [DATA_W-1:0]   rdata;

  logic                in_range, wr_ok, hit, ptr_last;
  logic                ptr_clr, ptr_inc, ram_re, load_dout, hs;

  assign in_range = (accum_addr[31:ADDR_W] == '0);
  assign wr_ok    = ready && accum_we && in_range;
  assign hit      = wr_ok && (accum_addr[ADDR_W-1:0] == ptr);
  assign ptr_last = (ptr == ADDR_W'(DEPTH - 1));

  assign busy       = (state != S_IDLE);
  assign dout_valid = (state == S_OUT);

  accum_dump_ram #(
    .DEPTH  (DEPTH),
    .DATA_W (DATA_W),
    .ADDR_W (ADDR_W)
  ) u_ram (
    .clk   (clk),
    .we    (wr_ok),
    .waddr (accum_addr[ADDR_W-1:0]),
    .wdata (accum_din),
    .re    (ram_re),
    .raddr (ptr),
    .rdata (rdata)
  );

  always_comb begin
    state_nx  = state;
    ptr_clr   = 1'b0;
    ptr_inc   = 1'b0;
    ram_re    = 1'b0;
    load_dout = 1'b0;
    hs        = 1'b0;
    case (state)
      S_IDLE: begin
        if (kick && ready) begin
          ptr_clr  = 1'b1;
          state_nx = S_SCAN;
        end
      end
      S_SCAN: begin
        if (vld[ptr]) begin
          ram_re   = 1'b1;
          state_nx = S_READ;
        end else begin
          ptr_inc  = 1'b1;
          state_nx = ptr_last ? S_DONE : S_SCAN;
        end
      end
      S_READ: begin
        load_dout = 1'b1;
        state_nx  = S_OUT;
      end
      S_OUT: begin
        if (dout_ready) begin
          hs       = 1'b1;
          ptr_inc  = 1'b1;
          state_nx = ptr_last ? S_DONE : S_SCAN;
        end
      end
      S_DONE:  state_nx = S_IDLE;
      default: state_nx = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state    <= S_IDLE;
      ready    <= 1'b0;
      vld      <= '0;
      ptr      <= '0;
      dirty    <= 1'b0;
      dout     <= '0;
      addr_err <= 1'b0;
    end else begin
      state <= state_nx;
      ready <= 1'b1;
      if (ptr_clr) begin
        ptr <= '0;
      end else if (ptr_inc) begin
        ptr <= ptr + ADDR_W'(1);
      end
      if (load_dout) begin
        dout <= rdata;
      end
      if (ready && accum_we && !in_range) begin
        addr_err <= 1'b1;
      end
      // dirty remembers a rewrite of the entry being drained, from the cycle
      // it was picked through its handshake, so the new contents survive.
      case (state)
        S_SCAN:        dirty <= vld[ptr] && hit;
        S_READ, S_OUT: dirty <= dirty || hit;
        default:       dirty <= 1'b0;
      endcase
      if (hs && !dirty) begin
        vld[ptr] <= 1'b0;
      end
      if (wr_ok) begin
        vld[accum_addr[ADDR_W-1:0]] <= 1'b1;
      end
    end
  end

`ifdef ACCUM_DUMP_COUNT_EN
  always_ff @(posedge clk) begin
    if (!reset) begin
      drained_cnt <= '0;
    end else if (ptr_clr) begin
      drained_cnt <= '0;
    end else if (hs) begin
      drained_cnt <= drained_cnt + (ADDR_W + 1)'(1);
    end
  end
`endif

endmodule
